// File: rtl/mips_pkg.sv
// Shared widths, constants and the ID/EX control payload for the MIPS decode stage.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic [ADDR_W-1:0] wr_addr;
  } id_ex_ctrl_t;

endpackage

// File: rtl/reg_file_bypass.sv
// Register file: two combinational read ports, one write port, optional
// hard-wired zero register and optional same-cycle write-back forwarding.
module reg_file_bypass #(
  parameter int unsigned DATA_W   = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_we;

  // Writes to the zero register are dropped when it is hard-wired.
  assign w_we = i_we & ~((ZERO_REG != 0) && (i_waddr == '0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = r_regs[a];
    if ((BYPASS != 0) && w_we && (i_waddr == a)) begin
      v = i_wdata;
    end
    if ((ZERO_REG != 0) && (a == '0)) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb begin
    o_rdata1 = rd_port(i_raddr1);
    o_rdata2 = rd_port(i_raddr2);
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Pipelined MIPS decode stage: register file read, destination select,
// load-use bubble insertion and a flow-controlled ID/EX register.
module decode_stage_pipe #(
  parameter int unsigned DATA_W   = mips_pkg::DATA_W,
  parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_rs,
  input  logic [ADDR_W-1:0] i_rt,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic              i_c_regDst,
  input  logic              i_c_regWrite,
  input  logic              i_c_memRead,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_ex_ready,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_op1,
  output logic [DATA_W-1:0] o_op2,
  output logic [ADDR_W-1:0] o_wrAddr,
  output logic              o_c_regWrite,
  output logic              o_c_memRead,
  output logic              o_hazard
);

  import mips_pkg::*;

  localparam int unsigned PKG_AW = mips_pkg::ADDR_W;

  id_ex_ctrl_t       r_ctrl;
  logic              r_valid;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;

  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_ld_addr;
  logic              w_ld_nonzero;
  logic              w_hazard;
  logic              w_stall;

  reg_file_bypass #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_rf (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (i_wb_we),
    .i_waddr  (i_wb_addr),
    .i_wdata  (i_wb_data),
    .i_raddr1 (i_rs),
    .i_raddr2 (i_rt),
    .o_rdata1 (w_rs_data),
    .o_rdata2 (w_rt_data)
  );

  assign w_wr_addr = i_c_regDst ? i_rd : i_rt;
  assign w_ld_addr = ADDR_W'(r_ctrl.wr_addr);

  // A load targeting the hard-wired zero register never creates a dependency.
  assign w_ld_nonzero = (r_ctrl.wr_addr != ZERO_ADDR) | (ZERO_REG == 0);
  assign w_hazard     = i_valid & r_valid & r_ctrl.mem_read & w_ld_nonzero &
                        ((w_ld_addr == i_rs) | (w_ld_addr == i_rt));
  assign w_stall      = r_valid & ~i_ex_ready;

  assign o_hazard = w_hazard;
  assign o_ready  = (i_ex_ready | ~r_valid) & ~w_hazard;

  // ID/EX register: reset > flush > stall hold > bubble > load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_ctrl  <= '0;
    end else if (i_flush) begin
      r_valid          <= 1'b0;
      r_ctrl.reg_write <= 1'b0;
      r_ctrl.mem_read  <= 1'b0;
    end else if (!w_stall) begin
      if (w_hazard) begin
        r_valid          <= 1'b0;
        r_ctrl.reg_write <= 1'b0;
        r_ctrl.mem_read  <= 1'b0;
      end else begin
        r_valid          <= i_valid;
        r_op1            <= w_rs_data;
        r_op2            <= w_rt_data;
        r_ctrl.reg_write <= i_valid & i_c_regWrite;
        r_ctrl.mem_read  <= i_valid & i_c_memRead;
        r_ctrl.wr_addr   <= PKG_AW'(w_wr_addr);
      end
    end
  end

  assign o_valid      = r_valid;
  assign o_op1        = r_op1;
  assign o_op2        = r_op2;
  assign o_wrAddr     = w_ld_addr;
  assign o_c_regWrite = r_ctrl.reg_write;
  assign o_c_memRead  = r_ctrl.mem_read;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe with a scoreboard of expected ID/EX entries.
module tb_decode_stage_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst, valid, ready, regdst, rw, mr, wb_we, ex_ready, flush;
  logic [AW-1:0] rs, rt, rd, wb_addr;
  logic [DW-1:0] wb_data;
  logic          o_valid, o_rw, o_mr, hazard;
  logic [DW-1:0] op1, op2;
  logic [AW-1:0] wr_addr;

  typedef struct packed {
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [AW-1:0] wr;
    logic          rw;
    logic          mr;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mdl [32];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  decode_stage_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_rs(rs), .i_rt(rt), .i_rd(rd),
    .i_c_regDst(regdst), .i_c_regWrite(rw), .i_c_memRead(mr),
    .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_ex_ready(ex_ready), .i_flush(flush),
    .o_valid(o_valid), .o_op1(op1), .o_op2(op2), .o_wrAddr(wr_addr),
    .o_c_regWrite(o_rw), .o_c_memRead(o_mr), .o_hazard(hazard)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference read: zero register, then same-cycle write-back forwarding, then stored value.
  function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (wb_we && (wb_addr == a)) return wb_data;
    return mdl[a];
  endfunction

  task automatic issue(input logic [AW-1:0] s, input logic [AW-1:0] t, input logic [AW-1:0] d,
                       input logic dst, input logic w, input logic m);
    valid = 1'b1; rs = s; rt = t; rd = d; regdst = dst; rw = w; mr = m;
  endtask

  // One clock: score consumed/squashed entries, record accepted input, update model, advance.
  task automatic cycle();
    exp_t e;
    #1;
    if (rst) begin
      sb.delete();
      for (int i = 0; i < 32; i++) mdl[i] = '0;
    end else begin
      if (!o_valid) chk("bubble_ctrl", DW'({o_rw, o_mr}), '0);
      if (o_valid && (ex_ready || flush)) begin
        chk("sb_nonempty", DW'(sb.size() != 0), DW'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          if (!flush) begin
            chk("sb_op1", op1, e.op1);
            chk("sb_op2", op2, e.op2);
            chk("sb_wr", DW'(wr_addr), DW'(e.wr));
            chk("sb_ctrl", DW'({o_rw, o_mr}), DW'({e.rw, e.mr}));
          end
        end
      end
      if (valid && ready && !flush) begin
        e.op1 = mrd(rs);
        e.op2 = mrd(rt);
        e.wr  = regdst ? rd : rt;
        e.rw  = rw;
        e.mr  = mr;
        sb.push_back(e);
      end
      if (wb_we && (wb_addr != '0)) mdl[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    valid = 0; rs = '0; rt = '0; rd = '0; regdst = 0; rw = 0; mr = 0;
    wb_we = 0; wb_addr = '0; wb_data = '0; ex_ready = 1; flush = 0;

    // Reset held two cycles against active instruction and write-back.
    rst = 1; valid = 1; wb_we = 1; wb_addr = 5'd5; wb_data = 32'hFFFF_FFFF;
    cycle(); cycle();
    rst = 0; valid = 0; wb_we = 0;
    chk("rst_valid", DW'(o_valid), '0);
    chk("rst_op1", op1, '0);
    chk("rst_op2", op2, '0);
    chk("rst_wr", DW'(wr_addr), '0);
    chk("rst_ctrl", DW'({o_rw, o_mr}), '0);

    // Every register reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      issue(AW'(i), AW'(31 - i), '0, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    valid = 0;

    // Write then read r5; writes to r0 are ignored.
    wb_we = 1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    cycle();
    wb_we = 0;
    issue(5'd5, 5'd0, '0, 1'b0, 1'b1, 1'b0);
    cycle();
    chk("rd_r5_op1", op1, 32'hDEAD_BEEF);
    chk("rd_r5_op2", op2, '0);
    valid = 0; wb_we = 1; wb_addr = 5'd0; wb_data = 32'h0000_1234;
    cycle();
    wb_we = 0;
    issue(5'd0, 5'd0, '0, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("rd_r0", op1, '0);

    // Same-cycle write-back forwarded to the read port.
    wb_we = 1; wb_addr = 5'd7; wb_data = 32'h0000_55AA;
    issue(5'd7, 5'd5, '0, 1'b0, 1'b0, 1'b0);
    cycle();
    wb_we = 0;
    chk("bypass_op1", op1, 32'h0000_55AA);
    chk("bypass_op2", op2, 32'hDEAD_BEEF);

    // Destination select.
    issue(5'd1, 5'd4, 5'd9, 1'b1, 1'b1, 1'b0);
    cycle();
    chk("dst_rd", DW'(wr_addr), DW'(9));
    chk("dst_rw", DW'(o_rw), DW'(1));
    regdst = 0;
    cycle();
    chk("dst_rt", DW'(wr_addr), DW'(4));

    // Load-use: load to r3, then a consumer of r3 costs one bubble.
    issue(5'd0, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1);
    cycle();
    chk("ld_memread", DW'(o_mr), DW'(1));
    issue(5'd3, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0);
    #1;
    chk("lu_hazard", DW'(hazard), DW'(1));
    chk("lu_ready", DW'(ready), '0);
    cycle();
    chk("lu_bubble", DW'(o_valid), '0);
    chk("lu_hazard_clr", DW'(hazard), '0);
    chk("lu_ready_set", DW'(ready), DW'(1));
    cycle();
    chk("lu_issue_valid", DW'(o_valid), DW'(1));
    chk("lu_issue_wr", DW'(wr_addr), DW'(10));

    // Load to r0 never creates a hazard.
    issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    cycle();
    issue(5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_r0_nohaz", DW'(hazard), '0);
    cycle();

    // Stall three cycles with a write-back landing mid-stall, then flush.
    issue(5'd5, 5'd7, 5'd12, 1'b1, 1'b1, 1'b0);
    cycle();
    ex_ready = 0;
    issue(5'd1, 5'd0, 5'd13, 1'b1, 1'b1, 1'b0);
    wb_we = 1; wb_addr = 5'd1; wb_data = 32'h0000_0077;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", DW'(ready), '0);
      cycle();
      wb_we = 0;
      chk("stall_valid", DW'(o_valid), DW'(1));
      chk("stall_wr", DW'(wr_addr), DW'(12));
      chk("stall_op1", op1, 32'hDEAD_BEEF);
    end
    flush = 1;
    cycle();
    flush = 0;
    chk("flush_valid", DW'(o_valid), '0);
    chk("flush_rw", DW'(o_rw), '0);
    ex_ready = 1;
    cycle();
    chk("post_stall_wb", op1, 32'h0000_0077);

    // Reset dominates a stalled pipeline and clears the register file.
    issue(5'd5, 5'd1, 5'd14, 1'b1, 1'b1, 1'b0);
    cycle();
    ex_ready = 0;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk("rst_stall_valid", DW'(o_valid), '0);
    chk("rst_stall_op1", op1, '0);
    ex_ready = 1;
    issue(5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("rst_clr_r5", op1, '0);
    valid = 0;
    cycle(); cycle();
    chk("sb_drained", DW'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised successor of the unpipelined decode stage for the MIPS core. Contains the register file, the write-destination select (Rt/Rd) and an ID/EX pipeline register with valid/ready flow control. Adds write-back bypass on register reads, load-use hazard detection with bubble insertion, and flush. Sits between the fetch/IF-ID register and the execute stage.

Parameters:
DATA_W, 32, register and operand width in bits
ADDR_W, 5, register address width; register count = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes
BYPASS, 1, 1 = same-cycle write-back data forwarded to read ports

Ports:
i_clk  in  1  clock; all state on rising edge
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  instruction present at decode inputs
o_ready  out  1  decode accepts the instruction this cycle
i_rs  in  ADDR_W  source register 1 address
i_rt  in  ADDR_W  source register 2 address
i_rd  in  ADDR_W  R-type destination address
i_c_regDst  in  1  1 = destination is i_rd, 0 = i_rt
i_c_regWrite  in  1  instruction writes the register file
i_c_memRead  in  1  instruction is a load
i_wb_we  in  1  write-back enable
i_wb_addr  in  ADDR_W  write-back address
i_wb_data  in  DATA_W  write-back data
i_ex_ready  in  1  execute stage accepts ID/EX contents
i_flush  in  1  squash ID/EX register and current input
o_valid  out  1  ID/EX register holds a live instruction
o_op1  out  DATA_W  registered operand 1 (Rs)
o_op2  out  DATA_W  registered operand 2 (Rt)
o_wrAddr  out  ADDR_W  registered destination address
o_c_regWrite  out  1  registered regWrite, forced 0 when o_valid=0
o_c_memRead  out  1  registered memRead, forced 0 when o_valid=0
o_hazard  out  1  combinational load-use hazard flag

Behaviour:
- Reset (i_rst=1 at edge): all registers of the file = 0; o_valid=0, o_op1=o_op2=0, o_wrAddr=0, o_c_regWrite=o_c_memRead=0. Reset dominates all other inputs, including mid-stall.
- Register file: write at edge when i_wb_we=1; with ZERO_REG=1 writes to address 0 are dropped and reads of 0 return 0. Reads combinational.
- Bypass (BYPASS=1): read address == i_wb_addr with i_wb_we=1 (and address nonzero when ZERO_REG=1) returns i_wb_data the same cycle. BYPASS=0: old value returned; new value visible next cycle.
- Destination: wrAddr = i_c_regDst ? i_rd : i_rt.
- Hazard: o_hazard = i_valid & o_valid & o_c_memRead & (o_wrAddr != 0 or ZERO_REG=0) & (o_wrAddr == i_rs or o_wrAddr == i_rt).
- o_ready = i_ex_ready | ~o_valid, gated to 0 by o_hazard. i_flush does not affect o_ready.
- ID/EX update priority at each edge: i_rst > i_flush (o_valid<=0) > ID/EX stalled (o_valid=1 and i_ex_ready=0: hold all outputs) > o_hazard (load advances, bubble inserted: o_valid<=0) > load (o_valid<=i_valid; operands, wrAddr, controls captured).
- Latency: one cycle decode->ID/EX. Throughput one instruction/cycle absent stall or hazard; load-use costs exactly one bubble.
- Bubble/invalid entries: o_c_regWrite and o_c_memRead forced 0; operands may hold any value.
- Write-back and decode of the same address in one cycle: bypass rule above; write happens regardless of stall/flush.

Decomposition:
- Package mips_pkg: DATA_W/ADDR_W defaults, ZERO_ADDR constant, ID/EX control struct (regWrite, memRead, wrAddr).
- One sub-module: reg_file_bypass (parametrised register file with 2 read ports, 1 write port, ZERO_REG and BYPASS options). Destination mux and hazard logic inline.

Test Plan:
- Reset: hold i_rst 2 cycles with i_valid=1, i_wb_we=1 -> o_valid=0, all outputs 0, every register reads 0 afterwards.
- Write/read: write 0xDEADBEEF to r5; next cycle decode rs=5,rt=0 -> after 1 cycle o_op1=0xDEADBEEF, o_op2=0; write r0=0x1234 -> r0 still reads 0.
- Bypass: same cycle wb r7=0x55AA and decode rs=7 -> o_op1=0x55AA next cycle (BYPASS=0 build: old value).
- Load-use: load to r3 in ID/EX, decode rs=3 -> o_hazard=1, o_ready=0, next cycle o_valid=0 bubble; following cycle instruction issues with o_valid=1.
- Stall/flush: i_ex_ready=0 for 3 cycles -> outputs held, o_ready=0; assert i_flush during stall -> o_valid=0 next edge, o_c_regWrite=0.
- rd/rt select: regDst=1 rd=9 rt=4 -> o_wrAddr=9; regDst=0 -> o_wrAddr=4.
